nn_dpmem: RTL

NN_DPMEM -- requirements
Module: nn_dpmem

---
 rtl/nn_dpmem.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/nn_dpmem.sv
// Dual-port word memory with a post-reset zero-clear sequencer and collision flag.
// Optional define NN_MEM_RDFWD_EN forwards same-address write data to the opposite port's read.
module nn_dpmem #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  input  logic          CSB1,
  input  logic          CSB2,
  input  logic          WEB1,
  input  logic          WEB2,
  input  logic          OEB1,
  input  logic          OEB2,
  input  logic [DW-1:0] D1,
  input  logic [DW-1:0] D2,
  output logic [DW-1:0] Q1,
  output logic [DW-1:0] Q2,
  output logic          Busy,
  output logic          Coll
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   ptr_r;
  logic            busy_r;
  logic            coll_r;
  logic [DW-1:0]   q1_r;
  logic [DW-1:0]   q2_r;
  logic [DW-1:0]   mem_r [0:(2**AW)-1];

  logic            wr1_s;
  logic            wr2_s;
  logic            rd1_s;
  logic            rd2_s;
  logic [DW-1:0]   rd1_data_s;
  logic [DW-1:0]   rd2_data_s;

  // Port decode: ports are locked out entirely while the clear sequence owns the array.
  always_comb begin
    wr1_s = 1'b0;
    wr2_s = 1'b0;
    rd1_s = 1'b0;
    rd2_s = 1'b0;
    if (!busy_r) begin
      wr1_s = !CSB1 && !WEB1;
      wr2_s = !CSB2 && !WEB2;
      rd1_s = !CSB1 &&  WEB1;
      rd2_s = !CSB2 &&  WEB2;
    end else begin
      wr1_s = 1'b0;
      wr2_s = 1'b0;
      rd1_s = 1'b0;
      rd2_s = 1'b0;
    end
  end

  // Read data selection, optionally bypassing the array with the other port's write data.
  always_comb begin
    rd1_data_s = mem_r[A1];
    rd2_data_s = mem_r[A2];
`ifdef NN_MEM_RDFWD_EN
    if (wr2_s && (A2 == A1)) begin
      rd1_data_s = D2;
    end else begin
      rd1_data_s = mem_r[A1];
    end
    if (wr1_s && (A1 == A2)) begin
      rd2_data_s = D1;
    end else begin
      rd2_data_s = mem_r[A2];
    end
`endif
  end

  // Clear sequencer: one zero-write per cycle, READY after the pointer wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLEAR;
      ptr_r   <= {AW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          ptr_r <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
          if (ptr_r == {AW{1'b1}}) begin
            state_r <= READY;
            busy_r  <= 1'b0;
          end else begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
          end
        end
        READY: begin
          state_r <= READY;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= CLEAR;
          ptr_r   <= {AW{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Array writes; port 2 is applied first so port 1 wins a same-address dual write.
  always_ff @(posedge clk) begin
    if (busy_r) begin
      mem_r[ptr_r] <= {DW{1'b0}};
    end else begin
      if (wr2_s) begin
        mem_r[A2] <= D2;
      end
      if (wr1_s) begin
        mem_r[A1] <= D1;
      end
    end
  end

  // Read registers and the registered collision pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_r   <= {DW{1'b0}};
      q2_r   <= {DW{1'b0}};
      coll_r <= 1'b0;
    end else begin
      if (rd1_s) begin
        q1_r <= rd1_data_s;
      end
      if (rd2_s) begin
        q2_r <= rd2_data_s;
      end
      coll_r <= wr1_s && wr2_s && (A1 == A2);
    end
  end

  assign Q1   = OEB1 ? {DW{1'b0}} : q1_r;
  assign Q2   = OEB2 ? {DW{1'b0}} : q2_r;
  assign Busy = busy_r;
  assign Coll = coll_r;

endmodule
